// File: rtl/cmp_match_scanner.sv
// cmp_match_scanner: steps one 4-bit equality compare per clock across a small table against a latched key
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data   host table write, honoured only while idle
//   start, key, first_only    scan request; key and mode latched when accepted in IDLE
//   busy                      high in SCAN and DONE
//   done                      one-cycle pulse when results are valid
//   found, match_idx          any match / lowest matching index (0 if none)
//   match_count               number of matching entries scanned
module cmp_match_scanner #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_data,
   input  logic          start,
   input  logic [3:0]    key,
   input  logic          first_only,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [AW-1:0] match_idx,
   output logic [AW:0]   match_count
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t        state;
   logic [3:0]    tbl [DEPTH];
   logic [3:0]    key_q;
   logic          first_only_q;
   logic [AW-1:0] idx;
   logic          hit;
   logic          last;
   // Shared equality datapath: every bit of entry XNOR key must be 1.
   assign hit  = &(tbl[idx] ~^ key_q);
   assign last = (idx == AW'(DEPTH - 1)) || (first_only_q && hit);
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         found        <= 1'b0;
         match_idx    <= '0;
         match_count  <= '0;
         idx          <= '0;
         key_q        <= '0;
         first_only_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) tbl[i] <= 4'b0000;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A write in the same cycle as start lands before the first compare.
               if (wr_en) tbl[wr_addr] <= wr_data;
               if (start) begin
                  state        <= SCAN;
                  busy         <= 1'b1;
                  key_q        <= key;
                  first_only_q <= first_only;
                  idx          <= '0;
                  found        <= 1'b0;
                  match_idx    <= '0;
                  match_count  <= '0;
               end
            end
            SCAN: begin
               if (hit) begin
                  match_count <= match_count + (AW+1)'(1);
                  if (!found) begin
                     found     <= 1'b1;
                     match_idx <= idx;
                  end
               end
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/cmp_match_scanner.md
# cmp_match_scanner

Sequencing controller for the 4-bit equality comparator. It holds a small table of 4-bit entries and, on command, steps one shared equality comparator across every entry against a latched key. It reports the first matching index and the total match count, using a start/busy/done handshake. It sits between a host that loads the table and the 4-bit equality datapath, which it reuses for one compare per clock.

## Interface
- DEPTH, 8: number of 4-bit table entries; power of two, 2..16
- AW, 3: index width; must equal log2(DEPTH)
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write index
- wr_data  in  4  table write data
- start  in  1  begin a scan; sampled only in IDLE
- key  in  4  compare key; latched on accepted start
- first_only  in  1  1 = stop at first match, 0 = scan all; latched on accepted start
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse when results are valid
- found  out  1  at least one entry equal to key
- match_idx  out  AW  lowest matching index; 0 if none
- match_count  out  AW+1  number of matching entries scanned

## Operation
- Equality per entry: all four bits of (entry XNOR key_q) ANDed. One compare per cycle. No magnitude compare.
- States: IDLE, SCAN, DONE.
- IDLE → SCAN when start=1:
  - latch key_q and first_only_q
  - idx=0
  - clear found, match_idx and match_count
- SCAN, each cycle:
  - compare table[idx] with key_q
  - on match: match_count+1; if found=0, set found=1 and match_idx=idx
  - go to DONE if idx=DEPTH-1, or if first_only_q=1 and a match occurred this cycle
  - otherwise idx+1
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Results (found, match_idx, match_count) hold from DONE until the next accepted start.
- Table writes:
  - honoured only in IDLE
  - wr_en while busy=1 is dropped, not queued
- start while busy=1 is ignored.
- A start in the same cycle as DONE is ignored. The earliest new start is accepted in the first IDLE cycle.
- Same-cycle wr_en and start in IDLE: the write commits, and the scan sees the new value. The write edge precedes the first compare.
- match_count width AW+1 holds DEPTH with no wrap.
- Reset:
  - state=IDLE; busy, done, found=0; match_idx=0; match_count=0; every table entry=4'b0000
  - rst mid-scan aborts immediately, with no done pulse

## Timing
- All outputs are registered. Let E0 be the edge that samples start=1 in IDLE.
- After E0: busy=1.
- Entry i is compared at edge E(i+1).
- Full scan: DONE entered at E(DEPTH); done=1 in that cycle; busy falls after E(DEPTH+1).
- first_only match at index i: done=1 after E(i+1).
- Total busy time:
  - full scan: DEPTH+1 cycles
  - early stop: i+2 cycles
- Minimum start-to-start spacing: DEPTH+2 cycles for a full scan.
- found, match_idx and match_count are final in the done cycle. During SCAN they show partial progress and must not be used.

## Test plan
- Reset: assert rst 2 cycles with random inputs. Required: busy=0, done=0, found=0, match_idx=0, match_count=0; then scan for key=4'h0 → found=1, match_idx=0, match_count=8.
- Full scan: table = {3,A,5,A,0,A,F,1}, key=A, first_only=0. Required: done exactly 8 cycles after E0; found=1, match_idx=1, match_count=3; busy high 9 cycles.
- First-only: same table, key=5, first_only=1. Required: done at E3; match_idx=2, match_count=1, found=1.
- No match: key=7, first_only=0. Required: done at E8; found=0, match_idx=0, match_count=0.
- Interference: during a scan, drive start=1 and write table[0]=A. Required: the scan result is unchanged and table[0] keeps its old value. A following start in IDLE with same-cycle wr_en table[7]=A, key=A, first_only=0 → match_count=4, match_idx=1.
- Reset mid-scan: assert rst at E3 of a full scan. Required: no done pulse; all outputs 0 next cycle; table cleared, so a rescan for key=0 → match_count=8.
